// File: rtl/mem_burst_arbiter_pkg.sv
// Shared types and helpers for the PSRAM burst arbiter: FSM state encoding,
// priority-mode selectors and a constant clog2 used for parameter-derived widths.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam int PRIO_FIXED = 0;
  localparam int PRIO_RR    = 1;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >>> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_burst_arbiter_prio_picker.sv
// Combinational channel picker: fixed (lowest index) or round-robin starting
// one past the previous grant. Returns a one-hot winner and a valid flag.
module prio_picker
  import mem_arb_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int PRIO_MODE = PRIO_RR,
  localparam int LG_W     = (N_CH > 1) ? clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0] i_eligible,
  input  logic [LG_W-1:0] i_last_grant,
  output logic [N_CH-1:0] o_winner,
  output logic            o_valid
);

  int   w_start;
  logic w_hit;

  // Walk channels in rotated priority order; first eligible one wins.
  always_comb begin
    w_hit    = 1'b0;
    o_winner = {N_CH{1'b0}};
    o_valid  = 1'b0;
    if (PRIO_MODE == PRIO_RR) begin
      w_start = (int'(i_last_grant) + 1) % N_CH;
    end else begin
      w_start = 0;
    end
    for (int d = 0; d < N_CH; d++) begin
      for (int c = 0; c < N_CH; c++) begin
        w_hit       = i_eligible[c] & ~o_valid & (((c - w_start + N_CH) % N_CH) == d);
        o_winner[c] = o_winner[c] | w_hit;
        o_valid     = o_valid | w_hit;
      end
    end
  end

endmodule

// File: rtl/mem_burst_arbiter.sv
// N-channel PSRAM burst arbiter with per-channel frame pointers, frame wrap,
// frame-sync restart and frame-done/primed status.
module mem_burst_arbiter
  import mem_arb_pkg::*;
#(
  parameter int              N_CH        = 2,
  parameter int              ADDR_W      = 23,
  parameter int              BRST_LEN    = 128,
  parameter int              FRAME_WORDS = 307200,
  parameter logic [N_CH-1:0] WR_MASK     = 2'b01,
  parameter int              PRIO_MODE   = PRIO_RR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        req,
  input  logic [N_CH-1:0]        frame_sync,
  input  logic [N_CH*ADDR_W-1:0] ch_base,
  output logic                   go,
  output logic                   wr,
  output logic [ADDR_W-1:0]      addr,
  input  logic                   done,
  output logic [N_CH-1:0]        grant,
  output logic [N_CH-1:0]        frame_done,
  output logic [N_CH-1:0]        primed
);

  localparam int OFF_W = clog2(FRAME_WORDS);
  localparam int LG_W  = (N_CH > 1) ? clog2(N_CH) : 1;
  localparam int SUM_W = (ADDR_W > OFF_W) ? ADDR_W : OFF_W;
  localparam logic [OFF_W:0] BRST_C  = (OFF_W+1)'(BRST_LEN);
  localparam logic [OFF_W:0] FRAME_C = (OFF_W+1)'(FRAME_WORDS);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [OFF_W-1:0]  r_off     [N_CH];
  logic [OFF_W-1:0]  w_off_nxt [N_CH];
  logic [OFF_W:0]    w_sum;
  logic [N_CH-1:0]   r_sync_pend;
  logic [N_CH-1:0]   w_pend_clr;
  logic [N_CH-1:0]   w_pend_nxt;
  logic [N_CH-1:0]   r_frame_done;
  logic [N_CH-1:0]   w_fd_nxt;
  logic [N_CH-1:0]   r_primed;
  logic              r_go;
  logic              w_go_nxt;
  logic              r_wr;
  logic              w_wr_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [N_CH-1:0]   r_grant;
  logic [N_CH-1:0]   w_grant_nxt;
  logic [LG_W-1:0]   r_last_grant;
  logic [LG_W-1:0]   w_last_nxt;
  logic [N_CH-1:0]   w_eligible;
  logic [N_CH-1:0]   w_winner;
  logic              w_win_valid;
  logic [LG_W-1:0]   w_win_idx;
  logic [ADDR_W-1:0] w_win_base;
  logic [OFF_W-1:0]  w_win_off;
  logic [ADDR_W-1:0] w_win_addr;
  logic              w_win_wr;
  logic              w_burst_end;

  // A channel with a pending restart sits out one arbitration round.
  assign w_eligible  = req & ~r_sync_pend;
  assign w_burst_end = (r_state == WAIT) && done;

  prio_picker #(
    .N_CH      (N_CH),
    .PRIO_MODE (PRIO_MODE)
  ) u_picker (
    .i_eligible   (w_eligible),
    .i_last_grant (r_last_grant),
    .o_winner     (w_winner),
    .o_valid      (w_win_valid)
  );

  // One-hot mux of the winner's index, base and offset.
  always_comb begin
    w_win_idx  = {LG_W{1'b0}};
    w_win_base = {ADDR_W{1'b0}};
    w_win_off  = {OFF_W{1'b0}};
    for (int c = 0; c < N_CH; c++) begin
      w_win_idx  = w_win_idx  | (w_winner[c] ? LG_W'(c) : {LG_W{1'b0}});
      w_win_base = w_win_base | (w_winner[c] ? ch_base[c*ADDR_W +: ADDR_W] : {ADDR_W{1'b0}});
      w_win_off  = w_win_off  | (w_winner[c] ? r_off[c] : {OFF_W{1'b0}});
    end
  end

  assign w_win_addr = ADDR_W'(SUM_W'(w_win_base) + SUM_W'(w_win_off));
  assign w_win_wr   = |(w_winner & WR_MASK);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; done only matters while waiting.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_win_valid) begin
          w_state_nxt = ISSUE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ISSUE: w_state_nxt = WAIT;
      WAIT: begin
        if (done) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = WAIT;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM output logic: next values of the bus-facing registers.
  always_comb begin
    w_go_nxt    = 1'b0;
    w_grant_nxt = r_grant;
    w_wr_nxt    = r_wr;
    w_addr_nxt  = r_addr;
    w_last_nxt  = r_last_grant;
    case (r_state)
      IDLE: begin
        if (w_win_valid) begin
          w_go_nxt    = 1'b1;
          w_grant_nxt = w_winner;
          w_wr_nxt    = w_win_wr;
          w_addr_nxt  = w_win_addr;
          w_last_nxt  = w_win_idx;
        end else begin
          w_grant_nxt = {N_CH{1'b0}};
        end
      end
      ISSUE: w_grant_nxt = r_grant;
      WAIT: begin
        if (done) begin
          w_grant_nxt = {N_CH{1'b0}};
        end else begin
          w_grant_nxt = r_grant;
        end
      end
      default: w_grant_nxt = {N_CH{1'b0}};
    endcase
  end

  // Bus-facing output registers and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_go         <= 1'b0;
      r_wr         <= 1'b0;
      r_addr       <= {ADDR_W{1'b0}};
      r_grant      <= {N_CH{1'b0}};
      r_last_grant <= LG_W'(N_CH - 1);
    end else begin
      r_go         <= w_go_nxt;
      r_wr         <= w_wr_nxt;
      r_addr       <= w_addr_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_nxt;
    end
  end

  // Per-channel pointer update: a pending sync beats a frame wrap at burst end.
  always_comb begin
    w_sum      = {(OFF_W+1){1'b0}};
    w_pend_clr = {N_CH{1'b0}};
    w_fd_nxt   = {N_CH{1'b0}};
    for (int c = 0; c < N_CH; c++) begin
      w_off_nxt[c] = r_off[c];
      w_sum        = {1'b0, r_off[c]} + BRST_C;
      if (w_burst_end && r_grant[c]) begin
        w_pend_clr[c] = r_sync_pend[c];
        if (r_sync_pend[c]) begin
          w_off_nxt[c] = {OFF_W{1'b0}};
        end else if (w_sum == FRAME_C) begin
          w_off_nxt[c] = {OFF_W{1'b0}};
          w_fd_nxt[c]  = 1'b1;
        end else begin
          w_off_nxt[c] = w_sum[OFF_W-1:0];
        end
      end else if ((r_state == IDLE) && r_sync_pend[c]) begin
        w_pend_clr[c] = 1'b1;
        w_off_nxt[c]  = {OFF_W{1'b0}};
      end else begin
        w_off_nxt[c] = r_off[c];
      end
    end
    w_pend_nxt = (r_sync_pend & ~w_pend_clr) | frame_sync;
  end

  // Per-channel pointer, sync and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < N_CH; c++) begin
        r_off[c] <= {OFF_W{1'b0}};
      end
      r_sync_pend  <= {N_CH{1'b0}};
      r_frame_done <= {N_CH{1'b0}};
      r_primed     <= {N_CH{1'b0}};
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        r_off[c] <= w_off_nxt[c];
      end
      r_sync_pend  <= w_pend_nxt;
      r_frame_done <= w_fd_nxt;
      r_primed     <= r_primed | w_fd_nxt;
    end
  end

  assign go         = r_go;
  assign wr         = r_wr;
  assign addr       = r_addr;
  assign grant      = r_grant;
  assign frame_done = r_frame_done;
  assign primed     = r_primed;

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Scoreboard bench: a transaction-level model predicts each burst start and
// frame-done pulse; monitors compare whenever the DUT presents them.
module tb_mem_burst_arbiter;

  localparam int NC = 2;
  localparam int AW = 23;
  localparam int BL = 128;
  localparam int FW = 512;

  typedef struct {
    logic [1:0]    grant;
    logic          wr;
    logic [AW-1:0] addr;
    logic [1:0]    primed;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            rst2 = 1'b1;
  logic [1:0]      req = 2'b00;
  logic [1:0]      frame_sync = 2'b00;
  logic [2*AW-1:0] ch_base;
  logic            go, wr, done = 1'b0;
  logic [AW-1:0]   addr;
  logic [1:0]      grant, frame_done, primed;
  logic            go2, wr2, done2 = 1'b0;
  logic [AW-1:0]   addr2;
  logic [1:0]      grant2, frame_done2, primed2;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   prev_go = 0;
  bit   aborted = 1'b0;
  bit   running = 1'b1;
  int   n_go2 = 0;
  int   m2_off = 0;

  logic [AW-1:0] bases [2];
  logic [1:0]    wrm = 2'b01;
  int            m_off [2];
  bit            m_pend [2];
  bit            m_primed [2];
  int            m_last;
  int            m_active;
  logic [1:0]    cur_req;
  exp_t          expq [$];
  logic [1:0]    fdq [$];
  exp_t          mon_e;
  logic [1:0]    mon_fd;

  mem_burst_arbiter #(.N_CH(NC), .ADDR_W(AW), .BRST_LEN(BL), .FRAME_WORDS(FW),
                      .WR_MASK(2'b01), .PRIO_MODE(1)) dut (
    .clk(clk), .rst(rst), .req(req), .frame_sync(frame_sync), .ch_base(ch_base),
    .go(go), .wr(wr), .addr(addr), .done(done), .grant(grant),
    .frame_done(frame_done), .primed(primed));

  mem_burst_arbiter #(.N_CH(NC), .ADDR_W(AW), .BRST_LEN(BL), .FRAME_WORDS(FW),
                      .WR_MASK(2'b01), .PRIO_MODE(0)) dut_fixed (
    .clk(clk), .rst(rst2), .req(2'b11), .frame_sync(2'b00), .ch_base(ch_base),
    .go(go2), .wr(wr2), .addr(addr2), .done(done2), .grant(grant2),
    .frame_done(frame_done2), .primed(primed2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference arbitration: round-robin search from one past the last winner.
  task automatic push_next(input logic [1:0] elig);
    exp_t e;
    int   w;
    int   c;
    w = -1;
    for (int k = 1; k <= NC; k++) begin
      c = (m_last + k) % NC;
      if (w < 0 && elig[c]) w = c;
    end
    e.grant  = 2'(1 << w);
    e.wr     = wrm[w];
    e.addr   = bases[w] + AW'(m_off[w]);
    e.primed = {m_primed[1], m_primed[0]};
    expq.push_back(e);
    m_last   = w;
    m_active = w;
  endtask

  // Burst completion followed by the first idle cycle's restarts and arbitration.
  task automatic model_done();
    int         c;
    logic [1:0] pv;
    c = m_active;
    if (m_pend[c]) begin
      m_off[c] = 0; m_pend[c] = 1'b0;
    end else if (m_off[c] + BL == FW) begin
      m_off[c] = 0; m_primed[c] = 1'b1;
      fdq.push_back(2'(1 << c));
    end else begin
      m_off[c] = m_off[c] + BL;
    end
    m_active = -1;
    pv = {m_pend[1], m_pend[0]};
    for (int k = 0; k < NC; k++) begin
      if (m_pend[k]) begin m_off[k] = 0; m_pend[k] = 1'b0; end
    end
    if (cur_req != 2'b00) push_next(((cur_req & ~pv) != 2'b00) ? (cur_req & ~pv) : cur_req);
  endtask

  task automatic model_reset();
    for (int k = 0; k < NC; k++) begin
      m_off[k] = 0; m_pend[k] = 1'b0; m_primed[k] = 1'b0;
    end
    m_last = NC - 1; m_active = -1;
    expq.delete(); fdq.delete();
  endtask

  task automatic wait_go(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (go === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL go_timeout: got no go within 40 cycles expected a burst start");
    end
  endtask

  task automatic do_burst(input int d, input logic [1:0] next_req, input logic [1:0] fs,
                          input bit gap, input bit spur, input bit chk_space);
    bit ok;
    if (aborted) return;
    wait_go(ok);
    if (!ok) begin aborted = 1'b1; return; end
    if (chk_space) check("go_spacing", 32'(cyc - prev_go), 32'd6);
    prev_go = cyc;
    if (spur) done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    req = gap ? 2'b00 : next_req;
    cur_req = req;
    frame_sync = fs;
    for (int k = 0; k < NC; k++) if (fs[k]) m_pend[k] = 1'b1;
    @(negedge clk);
    frame_sync = 2'b00;
    repeat (d - 1) @(negedge clk);
    done = 1'b1;
    model_done();
    @(negedge clk);
    done = 1'b0;
    if (gap) begin
      repeat (2) @(negedge clk);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      repeat (2) @(negedge clk);
      if (next_req != 2'b00) begin
        req = next_req; cur_req = next_req;
        push_next(next_req);
      end
    end
  endtask

  // Scoreboard monitor for the round-robin instance.
  always @(negedge clk) begin
    if (!rst && go === 1'b1) begin
      if (expq.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_go: got burst addr %0h grant %b expected no burst", addr, grant);
      end else begin
        mon_e = expq.pop_front();
        check("grant", 32'(grant), 32'(mon_e.grant));
        check("wr", 32'(wr), 32'(mon_e.wr));
        check("addr", 32'(addr), 32'(mon_e.addr));
        check("primed", 32'(primed), 32'(mon_e.primed));
      end
    end
    if (!rst && frame_done !== 2'b00) begin
      if (fdq.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_frame_done: got %b expected 00", frame_done);
      end else begin
        mon_fd = fdq.pop_front();
        check("frame_done", 32'(frame_done), 32'(mon_fd));
      end
    end
  end

  // Fixed-priority instance: with both channels always requesting only channel 0 runs.
  always @(negedge clk) begin
    if (!rst2 && go2 === 1'b1) begin
      n_go2++;
      check("fixed_grant", 32'(grant2), 32'd1);
      check("fixed_wr", 32'(wr2), 32'd1);
      check("fixed_addr", 32'(addr2), 32'(m2_off));
      m2_off = (m2_off + BL) % FW;
    end
  end

  initial begin : resp_fixed
    while (running) begin
      @(negedge clk);
      if (go2 === 1'b1) begin
        @(negedge clk);
        done2 = 1'b1;
        @(negedge clk);
        done2 = 1'b0;
      end
    end
  end

  initial begin : stim
    logic [1:0] nr, fs;
    bit         ok;
    bases[0] = 23'h000000;
    bases[1] = 23'h040000;
    ch_base  = {bases[1], bases[0]};
    model_reset();
    #1;
    check("rst_go", 32'(go), 32'd0);
    check("rst_wr", 32'(wr), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_primed", 32'(primed), 32'd0);
    @(negedge clk);
    req = 2'b01; cur_req = 2'b01;
    push_next(2'b01);
    rst = 1'b0; rst2 = 1'b0;

    // Single writer: two frames, fixed 4-cycle done latency.
    for (int i = 0; i < 8; i++) do_burst(3, 2'b01, 2'b00, 1'b0, 1'b0, i > 0);

    // Round-robin with a restart of channel 1 while it is at offset 256.
    for (int i = 0; i < 12; i++) begin
      fs = (m_active == 1 && m_off[1] == 256) ? 2'b10 : 2'b00;
      do_burst(int'($urandom_range(1, 4)), 2'b11, fs, 1'b0, 1'b0, 1'b0);
    end

    // Randomised traffic, syncs, idle gaps and spurious done pulses.
    for (int i = 0; i < 150; i++) begin
      nr = 2'($urandom_range(1, 3));
      fs = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      do_burst(int'($urandom_range(1, 4)), nr, fs, $urandom_range(0, 9) == 0,
               $urandom_range(0, 4) == 0, 1'b0);
    end

    // Reset in the middle of a burst.
    if (!aborted) begin
      wait_go(ok);
      if (!ok) aborted = 1'b1;
    end
    if (!aborted) begin
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_go", 32'(go), 32'd0);
      check("mid_rst_wr", 32'(wr), 32'd0);
      check("mid_rst_addr", 32'(addr), 32'd0);
      check("mid_rst_grant", 32'(grant), 32'd0);
      check("mid_rst_frame_done", 32'(frame_done), 32'd0);
      check("mid_rst_primed", 32'(primed), 32'd0);
      model_reset();
      req = 2'b00; cur_req = 2'b00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      repeat (2) @(negedge clk);
      req = 2'b11; cur_req = 2'b11;
      push_next(2'b11);
      for (int i = 0; i < 6; i++) begin
        nr = 2'($urandom_range(1, 3));
        do_burst(int'($urandom_range(1, 4)), (i == 5) ? 2'b00 : nr, 2'b00, i == 5, 1'b0, 1'b0);
      end
    end

    repeat (6) @(negedge clk);
    check("pending_bursts", 32'(expq.size()), 32'd0);
    check("pending_frame_done", 32'(fdq.size()), 32'd0);
    check("final_primed", 32'(primed), 32'({m_primed[1], m_primed[0]}));
    check("fixed_progress", 32'(n_go2 > 20), 32'd1);
    running = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_burst_arbiter.md
# mem_burst_arbiter

Parametrised N-channel burst arbiter and frame-address generator between the camera/VGA FIFOs and the PSRAM burst controller, in the burst clock domain (clk160). Each channel raises a level request from its FIFO watermark. The block grants one channel at a time using fixed or round-robin priority, issues a one-cycle burst start with a stable address and direction, and advances that channel's frame pointer on burst completion. It adds per-channel base addresses, frame wrap, frame-sync restart, and frame-done/primed status, which gate the VGA reset until a full frame has been stored.

## Interface
- N_CH, 2: number of channels (1..8).
- ADDR_W, 23: PSRAM word address width.
- BRST_LEN, 128: words per burst; power of two.
- FRAME_WORDS, 307200: words per frame; must be a multiple of BRST_LEN.
- WR_MASK, 2'b01: bit c=1 means channel c writes to memory, 0 means it reads.
- PRIO_MODE, 1: 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk  in  1  burst clock (clk160).
- rst  in  1  asynchronous, active-high reset.
- req  in  N_CH  level burst requests (FIFO prog_full/prog_empty).
- frame_sync  in  N_CH  one-cycle pulse; restart channel c at offset 0.
- ch_base  in  N_CH*ADDR_W  per-channel base address, slice c = [c*ADDR_W +: ADDR_W]; quasi-static.
- go  out  1  burst start pulse to the PSRAM controller.
- wr  out  1  burst direction: 1 = write, 0 = read.
- addr  out  ADDR_W  burst start address.
- done  in  1  burst complete pulse from the PSRAM controller.
- grant  out  N_CH  one-hot channel currently owning the bus.
- frame_done  out  N_CH  one-cycle pulse when channel c wraps.
- primed  out  N_CH  sticky; set at channel c's first wrap.

## Operation
- FSM states:
  - IDLE: apply pending syncs, then arbitrate. If any channel is eligible, go to ISSUE.
  - ISSUE: go=1 for exactly one cycle, then go to WAIT.
  - WAIT: hold until done=1, then go to IDLE.
- Eligibility: req[c]=1 and sync_pend[c]=0.
- Arbitration:
  - Fixed mode: lowest eligible index wins.
  - Round-robin mode: search starts at last_grant+1 modulo N_CH. last_grant resets to N_CH-1, so channel 0 has first priority.
- grant, wr = WR_MASK[winner], and addr = ch_base[winner] + offset[winner] (truncated to ADDR_W) are registered on the IDLE→ISSUE edge. They stay constant through ISSUE and WAIT.
- On the WAIT→IDLE edge for the granted channel c:
  - If sync_pend[c]: offset[c] becomes 0 and sync_pend[c] clears. No frame_done.
  - Else if offset[c]+BRST_LEN == FRAME_WORDS: offset[c] becomes 0, frame_done[c] pulses, primed[c] is set.
  - Else: offset[c] increments by BRST_LEN.
  - grant clears to 0.
- frame_sync[c] sets sync_pend[c] in any state.
- In IDLE, every pending channel that is not mid-burst has offset set to 0 and sync_pend cleared. That channel is not eligible in the same cycle, which costs a one-cycle bubble.
- Offset width is clog2(FRAME_WORDS). Offsets never exceed FRAME_WORDS-BRST_LEN.
- done is honoured only in WAIT; a done pulse in IDLE or ISSUE is ignored.
- Reset values: go=0, wr=0, addr=0, grant=0, frame_done=0, primed=0. All offsets and sync_pend are 0, and the FSM is in IDLE.
- Reset mid-burst: the FSM returns to IDLE and all pointers are cleared. The controller's in-flight done is ignored.

## Timing
- req[c] is sampled in IDLE at edge n. go is high during cycle n+1, and WAIT is entered at edge n+2.
- Minimum spacing between consecutive go pulses is 3 cycles: done at edge k, then IDLE, then ISSUE.
- Requests are level-sensitive. A req dropped during ISSUE or WAIT does not abort the burst.
- frame_done is high for exactly one cycle, the cycle after the completing done edge.
- primed rises in the same cycle as the first frame_done and holds until rst.
- frame_sync is applied in the first IDLE cycle after it is seen, or at burst end if the channel is active.

## Structure
- Package mem_arb_pkg holds:
  - the state typedef (IDLE, ISSUE, WAIT);
  - the PRIO_FIXED=0 and PRIO_RR=1 constants;
  - a clog2 function.
- Sub-module prio_picker (N_CH, PRIO_MODE) is purely combinational. It takes eligible and last_grant and returns a one-hot winner plus a valid flag.
- The top holds the FSM, the per-channel offset, sync_pend and primed registers, and the output registers.

## Test plan
- Single writer: N_CH=2, ch_base[0]=0, req[0] held high, done returned 4 cycles after each go. Expect addr 0,128,256,… and wr=1. go spacing must be 6 cycles.
- Wrap: FRAME_WORDS=512, BRST_LEN=128, four bursts on channel 0. Expect the fifth addr to be 0, frame_done[0] to pulse once, and primed[0]=1.
- Round-robin: req=2'b11 constantly. Expect grant order 01,10,01,10 with each channel's addr advancing independently (ch_base[1]=0x40000). With PRIO_MODE=0, expect only channel 0 to be granted.
- Sync mid-burst: frame_sync[1] asserted in WAIT while channel 1 is at offset 256. Expect the next channel-1 addr to equal ch_base[1] and no frame_done.
- Spurious done and reset: a done pulse in IDLE causes no state change. rst asserted in WAIT sets all outputs to 0 immediately, and the first post-reset go carries addr=ch_base[0].
